// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: sequencer state encoding and baud timing.
package uart_tx_fifo_pkg;

    localparam int UART_CLKS_PER_BIT = 48000000 / 115200;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_ram.sv
// Simple dual-port byte store with a registered, enabled read port (maps onto one EBR).
// The read register doubles as the held transmit byte, so it is reset and only loads on a pop.
module uart_tx_fifo_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk48,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk48) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads never collide with writes: a pop needs level!=0, so rd_addr differs from wr_addr
    // unless the FIFO is full, and then no write happens.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding uart_tx through its DV/Active/Done handshake.
// Optional high-water-mark tracking is enabled by defining UART_TX_FIFO_HWM_EN.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 8
) (
    input  logic                  clk48,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_v,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [WIDTH-1:0]      tx_byte,
    output logic                  tx_dv,
    input  logic                  tx_active,
    input  logic                  tx_done,
    output logic [DEPTH_LOG2:0]   hwm
);

    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2:0] wr_ptr_reg;
    logic [DEPTH_LOG2:0] rd_ptr_reg;
    logic                overflow_reg;
    logic                tx_dv_reg;
    tx_state_e           state_reg;
    tx_state_e           state_next;
    logic                wr_en;
    logic                pop;

    // Extra pointer bit distinguishes full from empty; subtraction wraps naturally.
    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign full     = (level == DEPTH);
    assign wr_en    = din_v && !full;
    assign overflow = overflow_reg;
    assign tx_dv    = tx_dv_reg;

    uart_tx_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (WIDTH)
    ) u_ram (
        .clk48   (clk48),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[DEPTH_LOG2-1:0]),
        .wr_data (din),
        .rd_en   (pop),
        .rd_addr (rd_ptr_reg[DEPTH_LOG2-1:0]),
        .rd_data (tx_byte)
    );

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
            tx_dv_reg    <= 1'b0;
            state_reg    <= ST_IDLE;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (din_v && full) begin
                overflow_reg <= 1'b1;
            end
            tx_dv_reg <= pop;
            state_reg <= state_next;
        end
    end

    // IDLE also waits on tx_active so a reset released mid-byte cannot restart uart_tx early.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (level != '0 && !tx_active) begin
                    pop        = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: state_next = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef UART_TX_FIFO_HWM_EN
    logic [DEPTH_LOG2:0] hwm_reg;

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            hwm_reg <= '0;
        end else if (level > hwm_reg) begin
            hwm_reg <= level;
        end
    end

    assign hwm = hwm_reg;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_tx responder and an in-order byte scoreboard.
module tb_uart_tx_fifo;

    localparam int DL2 = 6;
    localparam int W   = 8;

    logic           clk48 = 1'b0;
    logic           rst   = 1'b1;
    logic [W-1:0]   din   = '0;
    logic           din_v = 1'b0;
    logic           full;
    logic [DL2:0]   level;
    logic           overflow;
    logic [W-1:0]   tx_byte;
    logic           tx_dv;
    logic           tx_active;
    logic           tx_done = 1'b0;
    logic [DL2:0]   hwm;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         busy_cnt    = 0;
    int         bit_time    = 20;
    int         dv_count    = 0;
    bit         dv_pending  = 1'b0;
    logic       model_active = 1'b0;
    logic       stall       = 1'b0;

    assign tx_active = model_active | stall;

    uart_tx_fifo #(.DEPTH_LOG2(DL2), .WIDTH(W)) dut (
        .clk48     (clk48),
        .rst       (rst),
        .din       (din),
        .din_v     (din_v),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .tx_byte   (tx_byte),
        .tx_dv     (tx_dv),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .hwm       (hwm)
    );

    always #5 clk48 = ~clk48;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // uart_tx model: goes active the cycle after DV, pulses done after bit_time cycles
    initial begin
        forever begin
            @(posedge clk48); #1;
            tx_done = 1'b0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_done      = 1'b1;
                    model_active = 1'b0;
                end
            end else if (dv_pending) begin
                dv_pending   = 1'b0;
                model_active = 1'b1;
                busy_cnt     = bit_time;
            end
        end
    end

    // Monitor: every tx_dv must carry the next expected byte while uart_tx is idle
    initial begin
        forever begin
            @(negedge clk48);
            if (tx_dv === 1'b1) begin
                dv_count++;
                dv_pending = 1'b1;
                check("dv_while_active", {31'b0, tx_active}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_dv", {24'b0, tx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte_order", {24'b0, tx_byte}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk48); #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        din   = b;
        din_v = 1'b1;
        if (accept) exp_q.push_back(b);
        @(posedge clk48); #1;
        din_v = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && busy_cnt == 0 && !model_active && level == '0)
               && n < max_cycles) begin
            @(posedge clk48); #1;
            n++;
        end
        check(tag, {31'b0, n < max_cycles}, 32'd1);
        tick(3);
    endtask

    initial begin
        int dv_before;
        int n;
        logic [31:0] exp_hwm;

        // Reset state
        tick(3);
        check("rst_full",     {31'b0, full},     32'd0);
        check("rst_level",    {25'b0, level},    32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_tx_byte",  {24'b0, tx_byte},  32'd0);
        check("rst_tx_dv",    {31'b0, tx_dv},    32'd0);
        check("rst_hwm",      {25'b0, hwm},      32'd0);
        rst = 1'b0;
        tick(2);

        // Single byte into an empty FIFO: DV one edge after the write edge
        bit_time = 20;
        push(8'h41, 1'b1);
        check("t1_level_after_write", {25'b0, level}, 32'd1);
        check("t1_no_dv_yet",         {31'b0, tx_dv}, 32'd0);
        tick(1);
        check("t1_dv",      {31'b0, tx_dv},   32'd1);
        check("t1_tx_byte", {24'b0, tx_byte}, 32'h41);
        check("t1_level0",  {25'b0, level},   32'd0);
        wait_idle(200, "t1_drain");

        // Burst of 10 bytes with a full-length uart_tx byte time
        bit_time  = 4166;
        dv_before = dv_count;
        for (int i = 0; i < 10; i++) push(8'(i), 1'b1);
        wait_idle(50000, "t2_drain");
        check("t2_dv_count", dv_count - dv_before, 32'd10);

        // Pointer wrap: 200 bytes in bursts of 8
        bit_time = 3;
        for (int b = 0; b < 25; b++) begin
            for (int j = 0; j < 8; j++) push(8'(b * 8 + j), 1'b1);
            tick(80);
            check("t4_level_after_burst", {25'b0, level}, 32'd0);
        end
        wait_idle(500, "t4_drain");
        check("t4_no_overflow", {31'b0, overflow}, 32'd0);

        // Reset while the sequencer waits on a byte in flight
        bit_time = 200;
        push(8'hA5, 1'b1);
        n = 0;
        while (!model_active && n < 20) begin
            tick(1);
            n++;
        end
        check("t5_uart_busy", {31'b0, model_active}, 32'd1);
        push(8'h5A, 1'b0);
        tick(2);
        check("t5_level_before_rst", {25'b0, level}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_level",   {25'b0, level},   32'd0);
        check("t5_rst_tx_byte", {24'b0, tx_byte}, 32'd0);
        check("t5_rst_tx_dv",   {31'b0, tx_dv},   32'd0);
        check("t5_rst_full",    {31'b0, full},    32'd0);
        check("t5_rst_hwm",     {25'b0, hwm},     32'd0);
        tick(2);
        rst = 1'b0;
        dv_before = dv_count;
        push(8'hC3, 1'b1);
        tick(20);
        check("t5_no_dv_while_busy", dv_count - dv_before, 32'd0);
        check("t5_level_held",       {25'b0, level},      32'd1);
        wait_idle(400, "t5_drain");
        check("t5_dv_after_idle", dv_count - dv_before, 32'd1);

        // High-water mark: peak of 37 then drain
        bit_time = 4;
        stall    = 1'b1;
        for (int i = 0; i < 37; i++) push(8'(8'h80 + i), 1'b1);
        check("t6_level37", {25'b0, level}, 32'd37);
        stall = 1'b0;
        wait_idle(2000, "t6_drain");
`ifdef UART_TX_FIFO_HWM_EN
        exp_hwm = 32'd37;
`else
        exp_hwm = 32'd0;
`endif
        check("t6_hwm", {25'b0, hwm}, exp_hwm);

        // Overflow: 65 writes with uart_tx held busy
        stall = 1'b1;
        for (int i = 0; i < 64; i++) push(8'(i) ^ 8'h3C, 1'b1);
        check("t3_full_at_64",    {31'b0, full},     32'd1);
        check("t3_level_64",      {25'b0, level},    32'd64);
        check("t3_no_overflow63", {31'b0, overflow}, 32'd0);
        push(8'hEE, 1'b0);
        check("t3_overflow",      {31'b0, overflow}, 32'd1);
        check("t3_level_still64", {25'b0, level},    32'd64);
        check("t3_full_held",     {31'b0, full},     32'd1);
        stall = 1'b0;
        wait_idle(2000, "t3_drain");
        check("t3_empty",          {31'b0, full},     32'd0);
        check("t3_overflow_sticky", {31'b0, overflow}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
